// File: rtl/tff_counter_param.sv
// tff_counter_param: debounced push-button up/down counter built from T flip-flops,
// with clear, optional end saturation and a one-cycle wrap pulse.
module tff_counter_param #(
    parameter int WIDTH    = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             btn_step,
    input  logic             btn_dir,
    input  logic             btn_clear,
    input  logic             sat_en,
    output logic [WIDTH-1:0] led,
    output logic             wrap
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [WIDTH-1:0] MAXV = '1;
    logic [2:0] w_raw, w_lvl, w_evt;
    logic [WIDTH-1:0] w_tog;
    logic w_down, w_step, w_clr, w_at_end;
    assign w_raw = {btn_clear, btn_dir, btn_step};
    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic r_s1, r_s2, r_deb, r_prev;
        logic [CW-1:0] r_cnt;
        always_ff @(posedge sysclk or negedge reset_n) begin
            if (!reset_n) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_deb  <= 1'b0;
                r_prev <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_s1   <= w_raw[b];
                r_s2   <= r_s1;
                r_prev <= r_deb;
                if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
        assign w_lvl[b] = r_deb;
        assign w_evt[b] = r_deb & ~r_prev;
    end
    assign w_step = w_evt[0];
    assign w_down = w_lvl[1];
    assign w_clr  = w_evt[2];
    // T inputs: a bit toggles when every lower bit is at the carry (up) or borrow (down) value
    assign w_tog[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign w_tog[i] = w_down ? ~|led[i-1:0] : &led[i-1:0];
    end
    assign w_at_end = w_down ? (led == '0) : (led == MAXV);
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            led  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= w_step & ~w_clr & ~sat_en & w_at_end;
            if (w_clr)
                led <= '0;
            else if (w_step && !(sat_en && w_at_end))
                led <= led ^ w_tog;
        end
    end
endmodule

// File: tb/tb_tff_counter_param.sv
// tb_tff_counter_param: directed stimulus against a cycle-level behavioural model
// of the debounced counter, plus literal expectations after each scenario.
module tb_tff_counter_param;
    localparam int W = 3;
    localparam int D = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] raw = 3'b000;
    logic sat_en = 1'b0;
    logic [W-1:0] led;
    logic wrap;

    int n_chk = 0;
    int n_fail = 0;
    int n_wrap = 0;

    int m_led;
    logic m_wrap;
    logic [2:0] m_deb, m_prev, m_ev;
    logic [2:0] m_h [0:D];
    logic m_all;

    tff_counter_param #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .sysclk(clk),
        .reset_n(reset_n),
        .btn_step(raw[0]),
        .btn_dir(raw[1]),
        .btn_clear(raw[2]),
        .sat_en(sat_en),
        .led(led),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a button level flips once its synchronised value has disagreed with it
    // for D consecutive samples; the count itself is plain modular/saturating arithmetic.
    initial begin
        m_led = 0;
        m_wrap = 1'b0;
        m_deb = '0;
        m_prev = '0;
        for (int k = 0; k <= D; k++) m_h[k] = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_led = 0;
                m_wrap = 1'b0;
                m_deb = '0;
                m_prev = '0;
                for (int k = 0; k <= D; k++) m_h[k] = '0;
            end else begin
                m_ev = m_deb & ~m_prev;
                m_wrap = 1'b0;
                if (m_ev[2]) begin
                    m_led = 0;
                end else if (m_ev[0]) begin
                    if (!m_deb[1]) begin
                        if (m_led == MAXV) begin
                            if (!sat_en) begin
                                m_led = 0;
                                m_wrap = 1'b1;
                            end
                        end else m_led = m_led + 1;
                    end else begin
                        if (m_led == 0) begin
                            if (!sat_en) begin
                                m_led = MAXV;
                                m_wrap = 1'b1;
                            end
                        end else m_led = m_led - 1;
                    end
                end
                m_prev = m_deb;
                for (int b = 0; b < 3; b++) begin
                    m_all = 1'b1;
                    for (int k = 1; k <= D; k++) if (m_h[k][b] == m_deb[b]) m_all = 1'b0;
                    if (m_all) m_deb[b] = ~m_deb[b];
                end
                for (int k = D; k > 0; k--) m_h[k] = m_h[k-1];
                m_h[0] = raw;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        forever begin
            @(negedge clk);
            check("model_led", {29'b0, led}, m_led);
            check("model_wrap", {31'b0, wrap}, {31'b0, m_wrap});
            if (wrap === 1'b1) n_wrap++;
        end
    end

    task automatic press(input int b, input int hold);
        @(negedge clk);
        raw[b] = 1'b1;
        repeat (hold) @(negedge clk);
        raw[b] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) press(0, 6);
    endtask

    int w0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_led", {29'b0, led}, 0);
        check("reset_wrap", {31'b0, wrap}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        // first press: count must move exactly on the seventh sampling edge
        raw[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("before_edge7", {29'b0, led}, 0);
        @(negedge clk);
        check("at_edge7", {29'b0, led}, 1);
        raw[0] = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 2; i <= 5; i++) begin
            steps(1);
            check("up_seq", {29'b0, led}, i);
        end
        check("no_wrap_yet", n_wrap, 0);
        steps(2);
        check("at_max", {29'b0, led}, 7);
        steps(1);
        check("wrap_up_led", {29'b0, led}, 0);
        check("wrap_up_pulses", n_wrap, 1);
        steps(7);
        check("back_to_max", {29'b0, led}, 7);
        sat_en = 1'b1;
        steps(1);
        check("sat_up_led", {29'b0, led}, 7);
        check("sat_up_pulses", n_wrap, 1);
        press(2, 6);
        check("clear", {29'b0, led}, 0);
        raw[1] = 1'b1;
        repeat (12) @(negedge clk);
        steps(1);
        check("sat_down_led", {29'b0, led}, 0);
        sat_en = 1'b0;
        w0 = n_wrap;
        steps(1);
        check("wrap_down_led", {29'b0, led}, 7);
        check("wrap_down_pulse", n_wrap - w0, 1);
        steps(1);
        check("down_step", {29'b0, led}, 6);
        check("down_no_wrap", n_wrap - w0, 1);
        raw[1] = 1'b0;
        repeat (12) @(negedge clk);
        press(0, 3);
        check("glitch", {29'b0, led}, 6);
        press(0, 50);
        check("held_once", {29'b0, led}, 7);
        press(2, 6);
        steps(5);
        check("pre_simul", {29'b0, led}, 5);
        @(negedge clk);
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        repeat (6) @(negedge clk);
        raw = 3'b000;
        repeat (20) @(negedge clk);
        check("clear_wins", {29'b0, led}, 0);
        steps(4);
        check("pre_reset", {29'b0, led}, 4);
        @(negedge clk);
        raw[0] = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_led", {29'b0, led}, 0);
        check("async_wrap", {31'b0, wrap}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        raw[0] = 1'b0;
        repeat (15) @(negedge clk);
        check("no_spurious", {29'b0, led}, 0);
        steps(1);
        check("after_reset_step", {29'b0, led}, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tff_counter_param.md
Name: tff_counter_param

Overview:
- Parametrised successor to the 3-bit button-driven toggle counter. Generalised to WIDTH bits and built from T flip-flops.
- Adds on-chip button synchronisation and debouncing, up/down direction, clear, optional saturation, and a wrap pulse.
- Sits between the board push-buttons and the LED bank; the board top level feeds it raw buttons on sysclk.

Parameters:
- WIDTH, 3, counter/LED width in bits (legal range 1..16).
- DEBOUNCE, 4, number of consecutive stable synchronised samples needed to accept a button level change (legal range 1..65535).

Ports:
- sysclk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- btn_step  input  1  raw push-button; a press advances the count by one.
- btn_dir  input  1  raw switch/button level; debounced 0 = count up, 1 = count down.
- btn_clear  input  1  raw push-button; a press forces the count to 0.
- sat_en  input  1  static mode select; 1 = saturate at the ends, 0 = wrap. Not synchronised.
- led  output  WIDTH  current count value (registered).
- wrap  output  1  one-cycle pulse on max->0 (up) or 0->max (down) transition.

Behaviour:
- Reset (reset_n low, asynchronous): led=0, wrap=0, all synchronisers, debounce counters, debounced levels and previous-level registers = 0. Release is taken on the next sysclk edge.
- Input conditioning, per button (step, dir, clear), three identical instances:
  - 2-FF synchroniser.
  - Debounce counter, ceil(log2(DEBOUNCE+1)) bits. It increments when the synchronised value differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE samples is ignored.
- Event detection: event = debounced & ~debounced_prev (rising edge only). debounced_prev is registered every cycle. Releases generate no event.
- Latency: count the first edge that samples the raw input high as edge 1. The debounced level rises at edge DEBOUNCE+2. led updates at edge DEBOUNCE+3, which is edge 7 for DEBOUNCE=4.
- Count update, T-FF form, one step per event:
  - Up: bit i toggles iff bits [i-1:0] are all 1 (bit 0 always toggles).
  - Down: bit i toggles iff bits [i-1:0] are all 0 (bit 0 always toggles).
  - Direction is the debounced btn_dir level in the cycle the step event fires.
- Saturation: if sat_en=1 and the count is 2^WIDTH-1 going up, or 0 going down, the step event is dropped. led is unchanged and wrap stays 0.
- Wrap:
  - If sat_en=0, a step from 2^WIDTH-1 up gives 0, and a step from 0 down gives 2^WIDTH-1.
  - wrap=1 for exactly the cycle in which led takes the wrapped value (registered alongside led); otherwise wrap=0.
- Clear event: led <= 0 on the same edge the event is detected; wrap=0.
- Simultaneous events: clear has priority over step, and the step event is discarded (not queued).
- Holding a button: gives exactly one event per press; the button must be released and re-debounced to produce another.
- Reset mid-debounce: the partial count is lost, and the press is not registered after release of reset unless the raw button is still high for DEBOUNCE+2 further edges.
- WIDTH=1: the block degenerates to a single debounced T flip-flop. In that case up and down behave identically, and wrap pulses on every 1->0 (up) or 0->1 (down) toggle.

Test Plan:
- Reset then 5 clean step presses, dir=0, sat_en=0, WIDTH=3, DEBOUNCE=4 -> led sequence 1,2,3,4,5. Each update lands on edge 7 after the press begins; wrap=0 throughout.
- From led=7, one up step with sat_en=0 -> led=0 and a single-cycle wrap=1. Repeat with sat_en=1 -> led stays 7 and wrap=0.
- Set dir=1 (debounced), led=0, step with sat_en=0 -> led=7 with wrap pulse. Next step -> led=6 with wrap=0.
- Glitch: btn_step high for 3 cycles, then low -> no change to led. Step held high for 50 cycles -> exactly one increment.
- Clear and step pressed on the same cycle with led=5 -> led=0 and no increment follows.
- reset_n pulsed low mid-count (led=4) and mid-debounce -> led=0 and wrap=0 immediately (asynchronous); no spurious event after release.
